loop_ctrl: RTL and testbench
============================

Name: loop_ctrl

Overview:
- Loop-control stage directly upstream of the loop stack in the Brainfuck core.
- Decodes '[' (0x5B) and ']' (0x5D) from the fetch stage and drives the stack's pushd, push_en and pop_en.
- Uses the stack's top to redirect the program counter.
- Runs the forward-skip scan when a '[' is reached with the current cell equal to zero.

Parameters:
- PC_WIDTH, 8, program-counter width; equals the stack DATA_WIDTH.
- DEPTH_WIDTH, 5, loop-nesting counter width; equals the stack ADDR_WIDTH. MAX_DEPTH = 2^DEPTH_WIDTH.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- instr  in  8  current instruction byte (ASCII).
- instr_pc  in  PC_WIDTH  address of instr.
- instr_valid  in  1  instr/instr_pc/cell_zero are valid.
- instr_ready  out  1  instruction accepted this cycle.
- cell_zero  in  1  current data cell == 0; qualified by instr_valid.
- stack_top  in  PC_WIDTH  top output of the stack.
- stack_pushd  out  PC_WIDTH  data to push.
- stack_push_en  out  1  push on the next edge.
- stack_pop_en  out  1  pop on the next edge.
- pc_load  out  1  fetch stage must load pc_target instead of incrementing.
- pc_target  out  PC_WIDTH  redirect address.
- skipping  out  1  datapath must not execute the accepted instruction.
- error  out  1  sticky loop error.

Behaviour:
- State register: RUN, SKIP, ERR. The depth counter, skip counter and state are registered. Handshake and stack outputs are combinational from state plus the current instruction.
- Reset (rst low, asynchronous): state=RUN, depth=0, skip_cnt=0, error=0. All push/pop/pc_load outputs are 0 while in reset. instr_ready=0 while rst low.
- instr_ready = 1 in RUN and SKIP; 0 in ERR. An instruction is accepted on instr_valid & instr_ready. There is no back-pressure otherwise, so each accepted instruction is fully handled in its acceptance cycle.
- RUN, '[' with cell_zero=0:
  - stack_push_en=1, stack_pushd=instr_pc, depth+1.
  - No redirect.
- RUN, '[' with cell_zero=1:
  - No push. skip_cnt<=1, state<=SKIP.
  - skipping=1 in this cycle.
- RUN, ']' with cell_zero=0:
  - pc_load=1, pc_target=stack_top+1 (mod 2^PC_WIDTH wrap).
  - No pop; depth unchanged.
- RUN, ']' with cell_zero=1:
  - stack_pop_en=1, depth-1.
  - No redirect.
- RUN, any other byte: all outputs 0 and skipping=0; the datapath executes it.
- SKIP: every accepted instruction asserts skipping=1 and is not executed. Stack is never touched in SKIP.
  - '[' increments skip_cnt.
  - ']' decrements skip_cnt; when skip_cnt==1, state<=RUN and skip_cnt<=0. That ']' is consumed; the next instruction executes normally.
  - Other bytes are ignored (skipping=1).
- Stack timing: the stack updates top one edge after push/pop. A ']' accepted the cycle immediately after a push/pop must see the updated top; stack_top is registered in the stack, so this holds with no stall.
- Simultaneous events: push and pop are never both asserted. pc_load is only asserted in RUN.
- Reset mid-SKIP or mid-loop: all counters are cleared. The stack is reset by the same reset domain, so no orphaned entries remain.

Optional Feature:
- Macro: LOOP_CTRL_ERR_EN.
- Defined:
  - A '[' push with depth==MAX_DEPTH, or a ']' in RUN with depth==0, sets error=1 and state<=ERR.
  - The offending instruction causes no push/pop/redirect.
  - A skip_cnt overflow (skip_cnt at MAX) also enters ERR.
  - ERR holds instr_ready=0 until reset.
- Undefined:
  - error is tied to 0 and the ERR state is not built.
  - Depth and skip counters wrap silently, matching the stack pointer's wrap behaviour.

Decomposition:
- Shared package bf_pkg holds:
  - opcode constants OP_LOOP_OPEN=8'h5B and OP_LOOP_CLOSE=8'h5D;
  - the state enum {RUN, SKIP, ERR};
  - the default widths.
- One natural sub-module, loop_depth_cnt: an up/down counter with a zero/full flag. It is instantiated twice, for depth and for skip_cnt.

Test Plan:
- Reset: hold rst low for 3 cycles with instr_valid=1, instr=8'h5B → instr_ready=0, push_en=0, error=0. After release, depth=0 and state=RUN.
- Enter loop: '[' at pc=8'h10, cell_zero=0 → push_en=1, pushd=8'h10. Then ']' at 8'h14, cell_zero=0 → pc_load=1, pc_target=8'h11, pop_en=0.
- Exit loop: same '[' at 8'h10, then ']' at 8'h14 with cell_zero=1 → pop_en=1, pc_load=0, depth returns to 0.
- Skip nested: '[' at 8'h20 with cell_zero=1, followed by "[+]-]" → skipping=1 for all 6 bytes, no push/pop. The next '+' has skipping=0.
- Back-to-back: '[' (pc 8'h30), '[' (8'h31), ']' cell_zero=1, ']' cell_zero=0 on consecutive cycles → pushes 8'h30 and 8'h31, pops once, then pc_target=8'h31.
- Errors (LOOP_CTRL_ERR_EN): ']' at depth 0 → error=1, instr_ready=0 until reset. Separately, 32 nested '[' with cell_zero=0 then a 33rd → error=1, with no push on the 33rd.

Source files
------------

// File: rtl/bf_pkg.sv
// Shared definitions for the Brainfuck core: loop opcodes, loop-control
// state encoding and the default datapath widths.
package bf_pkg;

   localparam int PC_WIDTH_DEF    = 8;
   localparam int DEPTH_WIDTH_DEF = 5;

   localparam logic [7:0] OP_LOOP_OPEN  = 8'h5B;   // '['
   localparam logic [7:0] OP_LOOP_CLOSE = 8'h5D;   // ']'

   typedef enum logic [1:0] {
      RUN  = 2'd0,
      SKIP = 2'd1,
      ERR  = 2'd2
   } loop_state_t;

endpackage

// File: rtl/loop_depth_cnt.sv
// Up/down counter with zero and full flags. Full is the counter MSB, so a
// counter one bit wider than the nesting width flags exactly 2^(WIDTH-1).
module loop_depth_cnt #(
   parameter int WIDTH = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   input  logic             dec,
   output logic [WIDTH-1:0] count,
   output logic             zero,
   output logic             full
);

   // Count register; simultaneous inc and dec cancel out, overflow wraps.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count <= '0;
      end else if (inc && !dec) begin
         count <= count + WIDTH'(1);
      end else if (dec && !inc) begin
         count <= count - WIDTH'(1);
      end
   end

   assign zero = (count == '0);
   assign full = count[WIDTH-1];

endmodule

// File: rtl/loop_ctrl.sv
// Loop-control stage in front of the loop stack: decodes '[' and ']',
// drives push/pop, redirects the PC and runs the forward-skip scan.
// Optional macro LOOP_CTRL_ERR_EN builds the sticky ERR state with
// nesting overflow/underflow detection; without it counters wrap silently.
module loop_ctrl
   import bf_pkg::*;
#(
   parameter int PC_WIDTH    = PC_WIDTH_DEF,
   parameter int DEPTH_WIDTH = DEPTH_WIDTH_DEF
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [7:0]          instr,
   input  logic [PC_WIDTH-1:0] instr_pc,
   input  logic                instr_valid,
   output logic                instr_ready,
   input  logic                cell_zero,
   input  logic [PC_WIDTH-1:0] stack_top,
   output logic [PC_WIDTH-1:0] stack_pushd,
   output logic                stack_push_en,
   output logic                stack_pop_en,
   output logic                pc_load,
   output logic [PC_WIDTH-1:0] pc_target,
   output logic                skipping,
   output logic                error
);

`ifdef LOOP_CTRL_ERR_EN
   // One extra bit so a completely full stack (2^DEPTH_WIDTH entries) is visible.
   localparam int CW = DEPTH_WIDTH + 1;
`else
   localparam int CW = DEPTH_WIDTH;
`endif

   loop_state_t   state;
   loop_state_t   state_d;
   logic          accept;
   logic          depth_inc;
   logic          depth_dec;
   logic          skip_inc;
   logic          skip_dec;
   logic [CW-1:0] depth;
   logic [CW-1:0] skip_cnt;
   logic          depth_zero;
   logic          depth_full;
   logic          skip_zero;
   logic          skip_full;
   logic          unused_flags;

   loop_depth_cnt #(.WIDTH(CW)) u_depth (
      .clk   (clk),
      .rst   (rst),
      .inc   (depth_inc),
      .dec   (depth_dec),
      .count (depth),
      .zero  (depth_zero),
      .full  (depth_full)
   );

   loop_depth_cnt #(.WIDTH(CW)) u_skip (
      .clk   (clk),
      .rst   (rst),
      .inc   (skip_inc),
      .dec   (skip_dec),
      .count (skip_cnt),
      .zero  (skip_zero),
      .full  (skip_full)
   );

   // Flags not consulted in every build configuration.
   assign unused_flags = ^{depth_zero, depth_full, skip_zero, skip_full};

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= RUN;
      end else begin
         state <= state_d;
      end
   end

   // Decode of the accepted instruction; everything is handled in its acceptance cycle.
   always_comb begin
      instr_ready   = rst && (state != ERR);
      accept        = instr_valid && instr_ready;
      state_d       = state;
      stack_pushd   = '0;
      stack_push_en = 1'b0;
      stack_pop_en  = 1'b0;
      pc_load       = 1'b0;
      pc_target     = '0;
      skipping      = 1'b0;
      depth_inc     = 1'b0;
      depth_dec     = 1'b0;
      skip_inc      = 1'b0;
      skip_dec      = 1'b0;
      if (accept) begin
         case (state)
            RUN: begin
               if (instr == OP_LOOP_OPEN) begin
                  if (cell_zero) begin
                     skipping = 1'b1;
                     skip_inc = 1'b1;
                     state_d  = SKIP;
                  end
`ifdef LOOP_CTRL_ERR_EN
                  else if (depth_full) begin
                     state_d = ERR;
                  end
`endif
                  else begin
                     stack_push_en = 1'b1;
                     stack_pushd   = instr_pc;
                     depth_inc     = 1'b1;
                  end
               end else if (instr == OP_LOOP_CLOSE) begin
`ifdef LOOP_CTRL_ERR_EN
                  if (depth_zero) begin
                     state_d = ERR;
                  end else
`endif
                  if (cell_zero) begin
                     stack_pop_en = 1'b1;
                     depth_dec    = 1'b1;
                  end else begin
                     pc_load   = 1'b1;
                     pc_target = stack_top + PC_WIDTH'(1);
                  end
               end
            end
            SKIP: begin
               skipping = 1'b1;
               if (instr == OP_LOOP_OPEN) begin
`ifdef LOOP_CTRL_ERR_EN
                  if (skip_full) begin
                     state_d = ERR;
                  end else begin
                     skip_inc = 1'b1;
                  end
`else
                  skip_inc = 1'b1;
`endif
               end else if (instr == OP_LOOP_CLOSE) begin
                  skip_dec = 1'b1;
                  if (skip_cnt == CW'(1)) begin
                     state_d = RUN;
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

`ifdef LOOP_CTRL_ERR_EN
   assign error = (state == ERR);
`else
   assign error = 1'b0;
`endif

endmodule

// File: tb/tb_loop_ctrl.sv
// Directed bench for loop_ctrl with a small behavioural loop stack.
module tb_loop_ctrl;
   import bf_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] instr;
   logic [7:0] instr_pc;
   logic       instr_valid;
   logic       instr_ready;
   logic       cell_zero;
   logic [7:0] stack_top;
   logic [7:0] stack_pushd;
   logic       stack_push_en;
   logic       stack_pop_en;
   logic       pc_load;
   logic [7:0] pc_target;
   logic       skipping;
   logic       error;

   int tests_run    = 0;
   int tests_failed = 0;

   logic [7:0] mem [0:63];
   int         sp;

   loop_ctrl #(.PC_WIDTH(8), .DEPTH_WIDTH(5)) dut (
      .clk           (clk),
      .rst           (rst),
      .instr         (instr),
      .instr_pc      (instr_pc),
      .instr_valid   (instr_valid),
      .instr_ready   (instr_ready),
      .cell_zero     (cell_zero),
      .stack_top     (stack_top),
      .stack_pushd   (stack_pushd),
      .stack_push_en (stack_push_en),
      .stack_pop_en  (stack_pop_en),
      .pc_load       (pc_load),
      .pc_target     (pc_target),
      .skipping      (skipping),
      .error         (error)
   );

   always #5 clk = ~clk;

   // Loop stack model: registered top, updated one edge after push/pop.
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         sp = 0;
         stack_top <= 8'h00;
      end else begin
         if (stack_push_en && sp < 64) begin
            mem[sp] = stack_pushd;
            sp = sp + 1;
         end else if (stack_pop_en && sp > 0) begin
            sp = sp - 1;
         end
         stack_top <= (sp > 0) ? mem[sp-1] : 8'h00;
      end
   end

   task automatic drive(input logic [7:0] i, input logic [7:0] pc, input logic cz);
      @(negedge clk);
      instr       = i;
      instr_pc    = pc;
      cell_zero   = cz;
      instr_valid = 1'b1;
      #1;
   endtask

   task automatic idle();
      @(negedge clk);
      instr_valid = 1'b0;
      instr       = 8'h00;
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0;
      instr_valid = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b0; instr_valid = 1'b1; instr = 8'h5B; instr_pc = 8'h10; cell_zero = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      tests_run++;
      if (instr_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_ready: got %0b want 0", instr_ready); end
      tests_run++;
      if (stack_push_en !== 1'b0) begin tests_failed++; $display("FAIL reset_push_en: got %0b want 0", stack_push_en); end
      tests_run++;
      if (error !== 1'b0) begin tests_failed++; $display("FAIL reset_error: got %0b want 0", error); end
      tests_run++;
      if (stack_pop_en !== 1'b0 || pc_load !== 1'b0) begin tests_failed++; $display("FAIL reset_pop_pcload: got %0b%0b want 00", stack_pop_en, pc_load); end
      @(negedge clk);
      instr_valid = 1'b0;
      rst = 1'b1;
      #1;
      tests_run++;
      if (int'(dut.depth) !== 0) begin tests_failed++; $display("FAIL reset_depth: got %0d want 0", dut.depth); end
      tests_run++;
      if (dut.state !== RUN) begin tests_failed++; $display("FAIL reset_state: got %0d want %0d", dut.state, RUN); end
      tests_run++;
      if (instr_ready !== 1'b1) begin tests_failed++; $display("FAIL release_ready: got %0b want 1", instr_ready); end
   endtask

   task automatic test_enter_loop();
      drive(8'h5B, 8'h10, 1'b0);
      tests_run++;
      if (stack_push_en !== 1'b1 || stack_pushd !== 8'h10) begin tests_failed++; $display("FAIL enter_push: got en=%0b d=%0h want en=1 d=10", stack_push_en, stack_pushd); end
      tests_run++;
      if (skipping !== 1'b0 || pc_load !== 1'b0) begin tests_failed++; $display("FAIL enter_noredirect: got skip=%0b load=%0b want 0 0", skipping, pc_load); end
      drive(8'h5D, 8'h14, 1'b0);
      tests_run++;
      if (pc_load !== 1'b1 || pc_target !== 8'h11) begin tests_failed++; $display("FAIL enter_redirect: got load=%0b tgt=%0h want 1 11", pc_load, pc_target); end
      tests_run++;
      if (stack_pop_en !== 1'b0 || stack_push_en !== 1'b0) begin tests_failed++; $display("FAIL enter_nopop: got pop=%0b push=%0b want 0 0", stack_pop_en, stack_push_en); end
      drive(8'h5D, 8'h14, 1'b1);
      tests_run++;
      if (stack_pop_en !== 1'b1) begin tests_failed++; $display("FAIL enter_cleanup_pop: got %0b want 1", stack_pop_en); end
      idle();
   endtask

   task automatic test_exit_loop();
      drive(8'h5B, 8'h10, 1'b0);
      idle();
      tests_run++;
      if (int'(dut.depth) !== 1) begin tests_failed++; $display("FAIL exit_depth1: got %0d want 1", dut.depth); end
      drive(8'h5D, 8'h14, 1'b1);
      tests_run++;
      if (stack_pop_en !== 1'b1 || pc_load !== 1'b0) begin tests_failed++; $display("FAIL exit_pop: got pop=%0b load=%0b want 1 0", stack_pop_en, pc_load); end
      idle();
      tests_run++;
      if (int'(dut.depth) !== 0) begin tests_failed++; $display("FAIL exit_depth0: got %0d want 0", dut.depth); end
   endtask

   task automatic test_skip_nested();
      logic [7:0] body [0:4];
      int bad;
      body[0] = 8'h5B; body[1] = 8'h2B; body[2] = 8'h5D; body[3] = 8'h2D; body[4] = 8'h5D;
      drive(8'h5B, 8'h20, 1'b1);
      tests_run++;
      if (skipping !== 1'b1 || stack_push_en !== 1'b0) begin tests_failed++; $display("FAIL skip_open: got skip=%0b push=%0b want 1 0", skipping, stack_push_en); end
      bad = 0;
      for (int k = 0; k < 5; k++) begin
         drive(body[k], 8'h21 + 8'(k), 1'b0);
         if (skipping !== 1'b1 || stack_push_en !== 1'b0 || stack_pop_en !== 1'b0 || pc_load !== 1'b0) bad++;
         if (k == 2) begin
            tests_run++;
            if (int'(dut.skip_cnt) !== 2) begin tests_failed++; $display("FAIL skip_cnt_nested: got %0d want 2", dut.skip_cnt); end
         end
      end
      tests_run++;
      if (bad !== 0) begin tests_failed++; $display("FAIL skip_body: got %0d bad bytes want 0", bad); end
      drive(8'h2B, 8'h26, 1'b0);
      tests_run++;
      if (skipping !== 1'b0) begin tests_failed++; $display("FAIL skip_resume: got %0b want 0", skipping); end
      tests_run++;
      if (dut.state !== RUN || int'(dut.skip_cnt) !== 0) begin tests_failed++; $display("FAIL skip_state: got st=%0d cnt=%0d want 0 0", dut.state, dut.skip_cnt); end
      idle();
   endtask

   task automatic test_back_to_back();
      drive(8'h5B, 8'h30, 1'b0);
      tests_run++;
      if (stack_push_en !== 1'b1 || stack_pushd !== 8'h30) begin tests_failed++; $display("FAIL b2b_push0: got en=%0b d=%0h want 1 30", stack_push_en, stack_pushd); end
      drive(8'h5B, 8'h31, 1'b0);
      tests_run++;
      if (stack_push_en !== 1'b1 || stack_pushd !== 8'h31) begin tests_failed++; $display("FAIL b2b_push1: got en=%0b d=%0h want 1 31", stack_push_en, stack_pushd); end
      drive(8'h5D, 8'h32, 1'b1);
      tests_run++;
      if (stack_pop_en !== 1'b1 || pc_load !== 1'b0) begin tests_failed++; $display("FAIL b2b_pop: got pop=%0b load=%0b want 1 0", stack_pop_en, pc_load); end
      drive(8'h5D, 8'h33, 1'b0);
      tests_run++;
      if (pc_load !== 1'b1 || pc_target !== 8'h31) begin tests_failed++; $display("FAIL b2b_redirect: got load=%0b tgt=%0h want 1 31", pc_load, pc_target); end
      drive(8'h5D, 8'h33, 1'b1);
      idle();
      tests_run++;
      if (int'(dut.depth) !== 0) begin tests_failed++; $display("FAIL b2b_depth: got %0d want 0", dut.depth); end
   endtask

   task automatic test_pc_wrap();
      drive(8'h5B, 8'hFF, 1'b0);
      drive(8'h5D, 8'h05, 1'b0);
      tests_run++;
      if (pc_load !== 1'b1 || pc_target !== 8'h00) begin tests_failed++; $display("FAIL wrap_target: got load=%0b tgt=%0h want 1 00", pc_load, pc_target); end
      drive(8'h5D, 8'h05, 1'b1);
      idle();
   endtask

`ifdef LOOP_CTRL_ERR_EN
   task automatic test_errors();
      int pushes;
      drive(8'h5D, 8'h40, 1'b0);
      tests_run++;
      if (pc_load !== 1'b0 || stack_pop_en !== 1'b0) begin tests_failed++; $display("FAIL err_under_noop: got load=%0b pop=%0b want 0 0", pc_load, stack_pop_en); end
      idle();
      tests_run++;
      if (error !== 1'b1 || instr_ready !== 1'b0) begin tests_failed++; $display("FAIL err_under_flag: got err=%0b rdy=%0b want 1 0", error, instr_ready); end
      drive(8'h5B, 8'h41, 1'b0);
      idle();
      tests_run++;
      if (error !== 1'b1 || instr_ready !== 1'b0 || int'(dut.depth) !== 0) begin tests_failed++; $display("FAIL err_sticky: got err=%0b rdy=%0b depth=%0d want 1 0 0", error, instr_ready, dut.depth); end
      do_reset();
      pushes = 0;
      for (int k = 0; k < 32; k++) begin
         drive(8'h5B, 8'(k), 1'b0);
         if (stack_push_en === 1'b1) pushes++;
      end
      tests_run++;
      if (pushes !== 32) begin tests_failed++; $display("FAIL err_fill: got %0d pushes want 32", pushes); end
      drive(8'h5B, 8'h20, 1'b0);
      tests_run++;
      if (stack_push_en !== 1'b0) begin tests_failed++; $display("FAIL err_over_push: got %0b want 0", stack_push_en); end
      idle();
      tests_run++;
      if (error !== 1'b1 || instr_ready !== 1'b0) begin tests_failed++; $display("FAIL err_over_flag: got err=%0b rdy=%0b want 1 0", error, instr_ready); end
      do_reset();
      #1;
      tests_run++;
      if (error !== 1'b0 || instr_ready !== 1'b1) begin tests_failed++; $display("FAIL err_reset_clear: got err=%0b rdy=%0b want 0 1", error, instr_ready); end
   endtask
`else
   task automatic test_no_error();
      drive(8'h5D, 8'h40, 1'b0);
      tests_run++;
      if (pc_load !== 1'b1 || pc_target !== 8'h01) begin tests_failed++; $display("FAIL noerr_redirect: got load=%0b tgt=%0h want 1 01", pc_load, pc_target); end
      idle();
      tests_run++;
      if (error !== 1'b0 || instr_ready !== 1'b1) begin tests_failed++; $display("FAIL noerr_flag: got err=%0b rdy=%0b want 0 1", error, instr_ready); end
   endtask
`endif

   initial begin
      instr = 8'h00; instr_pc = 8'h00; instr_valid = 1'b0; cell_zero = 1'b0; rst = 1'b0;
      test_reset();
      test_enter_loop();
      test_exit_loop();
      test_skip_nested();
      test_back_to_back();
      test_pc_wrap();
`ifdef LOOP_CTRL_ERR_EN
      test_errors();
`else
      test_no_error();
`endif
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
